// File: rtl/p2s_out_collector_if.sv
// Bundle between the serial audio output stage and the collector:
// serial capture inputs plus the parallel FIFO read side and status flags.
interface p2s_out_collector_if #(
  parameter int WORD_W     = 40,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              Frame;
  logic              OutputL;
  logic              OutputR;
  logic              OutReady;
  logic              pop;
  logic [WORD_W-1:0] dout_l;
  logic [WORD_W-1:0] dout_r;
  logic              dout_valid;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic              resync_err;
  logic [7:0]        err_count;

  modport master (
    output Frame, OutputL, OutputR, OutReady, pop,
    input  dout_l, dout_r, dout_valid, fifo_count, overflow, resync_err, err_count
  );

  modport slave (
    input  Frame, OutputL, OutputR, OutReady, pop,
    output dout_l, dout_r, dout_valid, fifo_count, overflow, resync_err, err_count
  );
endinterface

// File: rtl/p2s_out_collector.sv
// Rebuilds MSB-first serial stereo words into a first-word-fall-through FIFO.
// Optional macro P2S_COLLECT_ERRCNT_EN enables the saturating error counter.
//
// state  | meaning
// IDLE   | waiting for Frame with OutReady
// SHIFT  | capturing bits WORD_W-2 .. 0
// COMMIT | word complete, written to FIFO this cycle
module p2s_out_collector #(
  parameter int WORD_W     = 40,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 Sclk,
  input logic                 Reset_n,
  p2s_out_collector_if.slave  bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BCW   = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  state_e            state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] sreg_l_q, sreg_l_d;
  logic [WORD_W-1:0] sreg_r_q, sreg_r_d;
  logic              resync_q, resync_d;
  logic              push;
  logic              start;

  logic [WORD_W-1:0] mem_l [FIFO_DEPTH];
  logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              full, do_pop, do_push, drop;

  assign start = bus.Frame && bus.OutReady;

  always_ff @(posedge Sclk) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sreg_l_q  <= '0;
      sreg_r_q  <= '0;
      resync_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_l_q  <= sreg_l_d;
      sreg_r_q  <= sreg_r_d;
      resync_q  <= resync_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sreg_l_d  = sreg_l_q;
    sreg_r_d  = sreg_r_q;
    resync_d  = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          bit_cnt_d = BCW'(1);
          sreg_l_d  = {sreg_l_q[WORD_W-2:0], bus.OutputL};
          sreg_r_d  = {sreg_r_q[WORD_W-2:0], bus.OutputR};
        end
      end
      SHIFT: begin
        sreg_l_d = {sreg_l_q[WORD_W-2:0], bus.OutputL};
        sreg_r_d = {sreg_r_q[WORD_W-2:0], bus.OutputR};
        // A Frame mid-word wins over completion: the partial word is abandoned
        if (bus.Frame) begin
          resync_d = 1'b1;
          if (bus.OutReady) begin
            bit_cnt_d = BCW'(1);
          end else begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end
        end else if (bit_cnt_q == BCW'(WORD_W - 1)) begin
          state_d   = COMMIT;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      COMMIT: begin
        push = 1'b1;
        if (start) begin
          state_d   = SHIFT;
          bit_cnt_d = BCW'(1);
          sreg_l_d  = {sreg_l_q[WORD_W-2:0], bus.OutputL};
          sreg_r_d  = {sreg_r_q[WORD_W-2:0], bus.OutputR};
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign do_pop  = bus.pop && (count_q != '0);
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge Sclk) begin
    if (do_push) begin
      mem_l[wr_ptr_q] <= sreg_l_q;
      mem_r[wr_ptr_q] <= sreg_r_q;
    end
  end

  always_ff @(posedge Sclk) begin
    if (!Reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.dout_valid = (count_q != '0);
  assign bus.dout_l     = bus.dout_valid ? mem_l[rd_ptr_q] : '0;
  assign bus.dout_r     = bus.dout_valid ? mem_r[rd_ptr_q] : '0;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.resync_err = resync_q;

`ifdef P2S_COLLECT_ERRCNT_EN
  logic [7:0] err_cnt_q;
  logic [8:0] err_sum;

  assign err_sum = {1'b0, err_cnt_q} + {8'h00, resync_d} + {8'h00, drop};

  always_ff @(posedge Sclk) begin
    if (!Reset_n) err_cnt_q <= 8'h00;
    else          err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = 8'h00;
`endif

endmodule

// File: tb/tb_p2s_out_collector.sv
// Bench for p2s_out_collector: directed vector table, hand sequences for
// framing/overflow corners, then a random stream against a word-level model.
module tb_p2s_out_collector;
  localparam int W    = 40;
  localparam int D    = 4;
  localparam int CW   = 3;
  localparam int MAXC = 6000;

  logic Sclk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Sclk = ~Sclk;

  p2s_out_collector_if #(.WORD_W(W), .FIFO_DEPTH(D)) bus ();
  p2s_out_collector #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
    .Sclk(Sclk), .Reset_n(Reset_n), .bus(bus)
  );

  int nchecks = 0;
  int nerrors = 0;

  typedef struct {
    logic          rdy;
    logic [W-1:0]  l;
    logic [W-1:0]  r;
    logic          exp_v;
    logic [W-1:0]  exp_l;
    logic [W-1:0]  exp_r;
    logic [CW-1:0] exp_cnt;
  } vec_t;
  vec_t tbl[5];

  // random stream and its expected events, indexed by cycle
  bit fr_q[$], rd_q[$], bl_q[$], br_q[$];
  logic         exp_push [MAXC];
  logic [W-1:0] exp_pl   [MAXC];
  logic [W-1:0] exp_pr   [MAXC];
  logic         exp_rs   [MAXC];
  logic [W-1:0] m_l[$], m_r[$];
  logic [W-1:0] lw, rw;
  bit   prev_ab, m_ovf, p, mfull, dp;
  int   m_err, t, k, s, nc, pct;

  function automatic int ee(input int n);
`ifdef P2S_COLLECT_ERRCNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic f, input logic rdy, input logic bl, input logic br, input logic pp);
    bus.Frame = f; bus.OutReady = rdy; bus.OutputL = bl; bus.OutputR = br; bus.pop = pp;
    @(posedge Sclk);
    @(negedge Sclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    idle(2);
    Reset_n = 1'b1;
  endtask

  // OutReady is randomised after the Frame cycle: it must have no effect mid-word
  task automatic send_word(input logic rdy, input logic [W-1:0] l, input logic [W-1:0] r);
    for (int i = 0; i < W; i++)
      cyc(i == 0, (i == 0) ? rdy : 1'($urandom_range(0, 1)), l[W-1-i], r[W-1-i], 1'b0);
  endtask

  task automatic gen_add(input bit f, input bit r, input bit a, input bit b);
    fr_q.push_back(f); rd_q.push_back(r); bl_q.push_back(a); br_q.push_back(b);
  endtask

  task automatic gen_full(input bit after_abort);
    int st;
    logic [W-1:0] gl, gr;
    st = fr_q.size();
    gl = W'({$urandom(), $urandom()});
    gr = W'({$urandom(), $urandom()});
    for (int i = 0; i < W; i++)
      gen_add(i == 0, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), gl[W-1-i], gr[W-1-i]);
    exp_push[st + W] = 1'b1;
    exp_pl[st + W]   = gl;
    exp_pr[st + W]   = gr;
    if (after_abort) exp_rs[st] = 1'b1;
  endtask

  initial begin
    bus.Frame = 0; bus.OutReady = 0; bus.OutputL = 0; bus.OutputR = 0; bus.pop = 0;
    @(negedge Sclk);
    do_reset();
    chk("reset_valid", bus.dout_valid, 0);
    chk("reset_count", bus.fifo_count, 0);
    chk("reset_dout_l", bus.dout_l, 0);
    chk("reset_ovf", bus.overflow, 0);
    chk("reset_err", bus.err_count, 0);

    // single words from an empty FIFO
    tbl[0] = '{1'b1, 40'h00_0000_1234, 40'hFF_FFFF_FFFE, 1'b1, 40'h00_0000_1234, 40'hFF_FFFF_FFFE, 3'd1};
    tbl[1] = '{1'b0, 40'h00_0000_DEAD, 40'h00_0000_BEEF, 1'b0, 40'h0, 40'h0, 3'd0};
    tbl[2] = '{1'b1, 40'h80_0000_0000, 40'h7F_FFFF_FFFF, 1'b1, 40'h80_0000_0000, 40'h7F_FFFF_FFFF, 3'd1};
    tbl[3] = '{1'b1, 40'hAA_AAAA_AAAA, 40'h55_5555_5555, 1'b1, 40'hAA_AAAA_AAAA, 40'h55_5555_5555, 3'd1};
    tbl[4] = '{1'b1, 40'h00_0000_0000, 40'hFF_FFFF_FFFF, 1'b1, 40'h00_0000_0000, 40'hFF_FFFF_FFFF, 3'd1};
    for (int v = 0; v < 5; v++) begin
      send_word(tbl[v].rdy, tbl[v].l, tbl[v].r);
      chk("tbl_valid_before_commit", bus.dout_valid, 0);
      idle(1);
      chk("tbl_valid", bus.dout_valid, tbl[v].exp_v);
      chk("tbl_dout_l", bus.dout_l, tbl[v].exp_l);
      chk("tbl_dout_r", bus.dout_r, tbl[v].exp_r);
      chk("tbl_count", bus.fifo_count, tbl[v].exp_cnt);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("tbl_count_after_pop", bus.fifo_count, 0);
      chk("tbl_ovf", bus.overflow, 0);
    end

    // Frame mid-word at bit_cnt=20, then a clean word
    do_reset();
    for (int i = 0; i < 20; i++) cyc(i == 0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    lw = 40'h5; rw = 40'hA;
    for (int i = 0; i < W; i++) begin
      cyc(i == 0, 1'b1, lw[W-1-i], rw[W-1-i], 1'b0);
      if (i == 0) chk("resync_pulse", bus.resync_err, 1);
      if (i == 1) chk("resync_one_cycle", bus.resync_err, 0);
    end
    idle(1);
    chk("resync_count", bus.fifo_count, 1);
    chk("resync_dout_l", bus.dout_l, 40'h5);
    chk("resync_dout_r", bus.dout_r, 40'hA);
    chk("resync_err_count", bus.err_count, ee(1));

    // five words, no pop, depth four
    do_reset();
    for (int n = 1; n <= 5; n++) send_word(1'b1, W'(n), W'(n + 16));
    idle(1);
    chk("ovf_count", bus.fifo_count, 4);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_err_count", bus.err_count, ee(1));
    for (int n = 1; n <= 4; n++) begin
      chk("ovf_pop_l", bus.dout_l, n);
      chk("ovf_pop_r", bus.dout_r, n + 16);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("ovf_drained", bus.dout_valid, 0);
    chk("ovf_sticky", bus.overflow, 1);

    // contiguous words, push+pop at full
    do_reset();
    send_word(1'b1, 40'h11, 40'h91); idle(1);
    send_word(1'b1, 40'h22, 40'h92); idle(1);
    send_word(1'b1, 40'hA0, 40'hB0);
    send_word(1'b1, 40'hA1, 40'hB1);
    send_word(1'b1, 40'hA2, 40'hB2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_count", bus.fifo_count, 4);
    chk("b2b_ovf", bus.overflow, 0);
    chk("b2b_err", bus.err_count, 0);
    chk("b2b_head", bus.dout_l, 40'h22);
    for (int n = 0; n < 3; n++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("b2b_pop_l", bus.dout_l, 40'hA0 + n);
      chk("b2b_pop_r", bus.dout_r, 40'hB0 + n);
    end

    // reset in the middle of a word
    do_reset();
    for (int i = 0; i < 15; i++) cyc(i == 0, 1'b1, 1'b1, 1'b1, 1'b0);
    Reset_n = 1'b0;
    idle(1);
    Reset_n = 1'b1;
    chk("rst_mid_valid", bus.dout_valid, 0);
    chk("rst_mid_count", bus.fifo_count, 0);
    send_word(1'b1, 40'h80_0000_0001, 40'h80_0000_0001);
    idle(1);
    chk("rst_clean_count", bus.fifo_count, 1);
    chk("rst_clean_l", bus.dout_l, 40'h80_0000_0001);
    chk("rst_clean_r", bus.dout_r, 40'h80_0000_0001);
    chk("rst_clean_ovf", bus.overflow, 0);
    chk("rst_clean_rs", bus.resync_err, 0);
    chk("rst_clean_err", bus.err_count, 0);

    // random stream: segments of full, aborted, sleeping words and gaps
    for (int i = 0; i < MAXC; i++) begin
      exp_push[i] = 1'b0; exp_pl[i] = '0; exp_pr[i] = '0; exp_rs[i] = 1'b0;
    end
    prev_ab = 1'b0;
    while (fr_q.size() < 4000) begin
      t = $urandom_range(0, 9);
      if (prev_ab && t == 9) t = 0;
      s = fr_q.size();
      if (t <= 5) begin
        gen_full(prev_ab);
        prev_ab = 1'b0;
      end else if (t <= 7) begin
        k = $urandom_range(1, W - 1);
        for (int i = 0; i < k; i++)
          gen_add(i == 0, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (prev_ab) exp_rs[s] = 1'b1;
        prev_ab = 1'b1;
      end else if (t == 8) begin
        k = $urandom_range(1, 5);
        for (int i = 0; i < k; i++)
          gen_add(i == 0, (i == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (prev_ab) exp_rs[s] = 1'b1;
        prev_ab = 1'b0;
      end else begin
        k = $urandom_range(1, 6);
        for (int i = 0; i < k; i++)
          gen_add(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    if (prev_ab) gen_full(1'b1);
    for (int i = 0; i < W + 2; i++) gen_add(1'b0, 1'b0, 1'b0, 1'b0);
    nc = fr_q.size();

    do_reset();
    m_l.delete(); m_r.delete(); m_ovf = 1'b0; m_err = 0;
    for (int c = 0; c < nc; c++) begin
      pct = ((c / 500) % 2 == 0) ? 1 : 40;
      p = ($urandom_range(0, 99) < pct);
      cyc(fr_q[c], rd_q[c], bl_q[c], br_q[c], p);
      mfull = (m_l.size() == D);
      dp = p && (m_l.size() > 0);
      if (dp) begin
        void'(m_l.pop_front());
        void'(m_r.pop_front());
      end
      if (exp_push[c]) begin
        if (mfull && !dp) begin
          m_ovf = 1'b1;
          m_err++;
        end else begin
          m_l.push_back(exp_pl[c]);
          m_r.push_back(exp_pr[c]);
        end
      end
      if (exp_rs[c]) m_err++;
      chk("rnd_valid", bus.dout_valid, m_l.size() > 0);
      chk("rnd_count", bus.fifo_count, m_l.size());
      chk("rnd_dout_l", bus.dout_l, (m_l.size() > 0) ? m_l[0] : '0);
      chk("rnd_dout_r", bus.dout_r, (m_r.size() > 0) ? m_r[0] : '0);
      chk("rnd_ovf", bus.overflow, m_ovf);
      chk("rnd_resync", bus.resync_err, exp_rs[c]);
      chk("rnd_err_count", bus.err_count, ee(m_err));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
